// File: rtl/commit_trace_checker.sv
// +----------------------------------------------------------------------------+
// | commit_trace_checker: compares the CPU commit trace against a golden ROM.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module commit_trace_checker #(
  parameter int N_RECORDS  = 256,
  parameter int GOLD_AW    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               trace_valid,
  input  logic [31:0]        trace_pc,
  input  logic [31:0]        trace_inst,
  input  logic               trace_rf_we,
  input  logic [4:0]         trace_rf_addr,
  input  logic [31:0]        trace_rf_wdata,
  output logic               gold_rd_en,
  output logic [GOLD_AW-1:0] gold_addr,
  input  logic [31:0]        gold_rdata,
  output logic               done,
  output logic               pass,
  output logic [2:0]         fail_field,
  output logic [15:0]        fail_index,
  output logic [15:0]        match_count,
  output logic               overflow
);

  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam int             EW       = 102;
  localparam logic [PW:0]    FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [15:0]    LAST_IDX = 16'(N_RECORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_F3   = 3'd4,
    S_CMP  = 3'd5,
    S_DONE = 3'd6,
    S_FAIL = 3'd7
  } state_t;

  state_t state, state_nx;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty, fifo_full;
  logic          push_req, do_push, do_pop, ovf_hit;
  logic [EW-1:0] head;

  logic [31:0]   cur_pc, cur_inst, cur_wdata;
  logic          cur_we;
  logic [4:0]    cur_addr;
  logic [31:0]   gold_pc, gold_inst;
  logic          gold_we;
  logic [4:0]    gold_rd;
  logic [15:0]   index;

  logic          pc_bad, inst_bad, wb_bad, mismatch, last_rec;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push_req   = trace_valid && !done;
  assign do_pop     = (state == S_IDLE) && !fifo_empty && !done;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign ovf_hit    = push_req && fifo_full && !do_pop;
  assign head       = fifo_mem[rd_ptr];

  assign pc_bad   = (cur_pc != gold_pc);
  assign inst_bad = (cur_inst != gold_inst);
  assign wb_bad   = (cur_we != gold_we) ||
                    (cur_we && ((cur_addr != gold_rd) || (cur_wdata != gold_rdata)));
  assign mismatch = pc_bad || inst_bad || wb_bad;
  assign last_rec = (index == LAST_IDX);

  always_comb begin
    state_nx   = state;
    gold_rd_en = 1'b0;
    gold_addr  = '0;
    case (state)
      S_IDLE: if (do_pop) state_nx = S_F0;
      S_F0: begin
        gold_rd_en = 1'b1;
        gold_addr  = {index[GOLD_AW-3:0], 2'd0};
        state_nx   = S_F1;
      end
      S_F1: begin
        gold_rd_en = 1'b1;
        gold_addr  = {index[GOLD_AW-3:0], 2'd1};
        state_nx   = S_F2;
      end
      S_F2: begin
        gold_rd_en = 1'b1;
        gold_addr  = {index[GOLD_AW-3:0], 2'd2};
        state_nx   = S_F3;
      end
      S_F3: begin
        gold_rd_en = 1'b1;
        gold_addr  = {index[GOLD_AW-3:0], 2'd3};
        state_nx   = S_CMP;
      end
      S_CMP: begin
        if (mismatch)      state_nx = S_FAIL;
        else if (last_rec) state_nx = S_DONE;
        else               state_nx = S_IDLE;
      end
      default: state_nx = state;
    endcase
    if (ovf_hit) state_nx = S_FAIL;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Storage is not reset; pointer/count reset is what empties the FIFO.
  always_ff @(posedge clk_in) begin
    if (do_push) fifo_mem[wr_ptr] <= {trace_pc, trace_inst, trace_rf_we, trace_rf_addr, trace_rf_wdata};
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cur_pc    <= '0;
      cur_inst  <= '0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      gold_pc   <= '0;
      gold_inst <= '0;
      gold_we   <= 1'b0;
      gold_rd   <= '0;
    end else begin
      if (do_pop) {cur_pc, cur_inst, cur_we, cur_addr, cur_wdata} <= head;
      if (state == S_F1) gold_pc   <= gold_rdata;
      if (state == S_F2) gold_inst <= gold_rdata;
      if (state == S_F3) begin
        gold_we <= gold_rdata[31];
        gold_rd <= gold_rdata[4:0];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      index       <= '0;
      match_count <= '0;
      fail_field  <= '0;
      fail_index  <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (state == S_CMP) begin
        if (mismatch) begin
          fail_field <= {wb_bad, inst_bad, pc_bad};
          fail_index <= index;
          done       <= 1'b1;
          pass       <= 1'b0;
        end else begin
          match_count <= match_count + 16'd1;
          index       <= index + 16'd1;
          if (last_rec) begin
            done <= 1'b1;
            pass <= 1'b1;
          end
        end
      end
      // A dropped commit invalidates the run regardless of what CMP decided.
      if (ovf_hit) begin
        overflow <= 1'b1;
        done     <= 1'b1;
        pass     <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_checker.sv
// Self-checking bench for commit_trace_checker: golden ROM model plus a
// scoreboard of expected match_count steps.
`default_nettype none

module tb_commit_trace_checker;

  localparam int NREC  = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic          trace_valid = 1'b0;
  logic [31:0]   trace_pc = '0;
  logic [31:0]   trace_inst = '0;
  logic          trace_rf_we = 1'b0;
  logic [4:0]    trace_rf_addr = '0;
  logic [31:0]   trace_rf_wdata = '0;
  logic          gold_rd_en;
  logic [AW-1:0] gold_addr;
  logic [31:0]   gold_rdata = '0;
  logic          done, pass, overflow;
  logic [2:0]    fail_field;
  logic [15:0]   fail_index, match_count;

  logic [31:0]   gold_mem [0:(1<<AW)-1];
  int            total = 0;
  int            bad = 0;
  int            exp_q[$];
  int            sb_next = 0;
  int            prev_mc = 0;

  commit_trace_checker #(.N_RECORDS(NREC), .GOLD_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .reset(reset), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_inst(trace_inst), .trace_rf_we(trace_rf_we), .trace_rf_addr(trace_rf_addr),
    .trace_rf_wdata(trace_rf_wdata), .gold_rd_en(gold_rd_en), .gold_addr(gold_addr),
    .gold_rdata(gold_rdata), .done(done), .pass(pass), .fail_field(fail_field),
    .fail_index(fail_index), .match_count(match_count), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (gold_rd_en) gold_rdata <= gold_mem[gold_addr];

  function automatic logic [31:0] rec_pc(input int k);   return 32'h0040_0000 + 32'(k * 4); endfunction
  function automatic logic [31:0] rec_inst(input int k); return 32'h2008_0001 + 32'(k * 4); endfunction
  function automatic logic        rec_we(input int k);   return (k != 0); endfunction
  function automatic logic [4:0]  rec_ra(input int k);   return (k == 0) ? 5'd0 : 5'(7 + k); endfunction
  function automatic logic [31:0] rec_wd(input int k);   return 32'(k * 5 + 1); endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_fields(input int k, input logic [31:0] inst, input logic [31:0] wd);
    trace_pc       = rec_pc(k);
    trace_inst     = inst;
    trace_rf_we    = rec_we(k);
    trace_rf_addr  = rec_ra(k);
    trace_rf_wdata = wd;
  endtask

  // m=1 means this commit is expected to match, so one more match_count step is due.
  task automatic commit(input int k, input logic [31:0] inst, input logic [31:0] wd, input bit m);
    set_fields(k, inst, wd);
    if (m) begin
      sb_next++;
      exp_q.push_back(sb_next);
    end
    trace_valid = 1'b1;
    cyc();
    trace_valid = 1'b0;
  endtask

  task automatic send(input int k, input bit m);
    commit(k, rec_inst(k), rec_wd(k), m);
  endtask

  task automatic do_reset();
    trace_valid = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    exp_q.delete();
    sb_next = 0;
    reset = 1'b0;
  endtask

  task automatic wait_for(input int mc, input bit want_done);
    int n = 0;
    while (!((want_done && done) || (!want_done && int'(match_count) == mc)) && n < 300) begin
      cyc();
      n++;
    end
    if (n >= 300) chk("wait_timeout", 32'(n), 32'(0));
  endtask

  always @(negedge clk_in) begin
    if (reset) prev_mc = 0;
    else if (int'(match_count) != prev_mc) begin
      if (exp_q.size() == 0) chk("mc_spurious", 32'(match_count), 32'(prev_mc));
      else                   chk("mc_step", 32'(match_count), 32'(exp_q.pop_front()));
      prev_mc = int'(match_count);
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) gold_mem[i] = '0;
    for (int k = 0; k < NREC; k++) begin
      gold_mem[4*k]     = rec_pc(k);
      gold_mem[4*k + 1] = rec_inst(k);
      gold_mem[4*k + 2] = {rec_we(k), 26'b0, rec_ra(k)};
      gold_mem[4*k + 3] = rec_wd(k);
    end

    // Reset state
    cyc();
    chk("rst_flags", {9'b0, match_count, fail_field, done, pass, overflow, gold_rd_en}, 32'h0);
    chk("rst_fidx", {16'b0, fail_index}, 32'h0);
    chk("rst_addr", 32'(gold_addr), 32'h0);
    do_reset();

    // All records match, commits 3 cycles apart
    for (int k = 0; k < NREC; k++) begin
      send(k, 1'b1);
      cyc();
      cyc();
    end
    wait_for(0, 1'b1);
    cyc(); cyc();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_field", 32'(fail_field), 32'd0);
    chk("t1_mc", 32'(match_count), 32'(NREC));
    chk("t1_ovf", 32'(overflow), 32'd0);
    chk("t1_rden", 32'(gold_rd_en), 32'd0);
    chk("t1_q", 32'(exp_q.size()), 32'd0);

    // Inst mismatch on record 1
    do_reset();
    send(0, 1'b1);
    cyc(); cyc();
    commit(1, 32'h2008_000A, rec_wd(1), 1'b0);
    wait_for(0, 1'b1);
    cyc(); cyc();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_field", 32'(fail_field), 32'b010);
    chk("t2_fidx", 32'(fail_index), 32'd1);
    chk("t2_mc", 32'(match_count), 32'd1);

    // Writeback: rf_we=0 ignores wdata, rf_we=1 wdata mismatch fails
    do_reset();
    commit(0, rec_inst(0), 32'h0000_DEAD, 1'b1);
    cyc(); cyc();
    commit(1, rec_inst(1), 32'h5, 1'b0);
    wait_for(0, 1'b1);
    cyc(); cyc();
    chk("t3_field", 32'(fail_field), 32'b100);
    chk("t3_fidx", 32'(fail_index), 32'd1);
    chk("t3_mc", 32'(match_count), 32'd1);
    chk("t3_pass", 32'(pass), 32'd0);

    // Commit every cycle until the FIFO overflows
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_fields(i % NREC, rec_inst(i % NREC), rec_wd(i % NREC));
      trace_valid = 1'b1;
      cyc();
    end
    trace_valid = 1'b0;
    cyc(); cyc();
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);
    chk("t4_mc", 32'(match_count), 32'd0);
    chk("t4_field", 32'(fail_field), 32'd0);

    // Reset in F2 of record 1, then replay record 0
    do_reset();
    send(0, 1'b1);
    wait_for(1, 1'b0);
    cyc();
    send(1, 1'b0);
    cyc(); cyc(); cyc();
    chk("t5_rden_f2", 32'(gold_rd_en), 32'd1);
    chk("t5_addr_f2", 32'(gold_addr), 32'd6);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_flags", {9'b0, match_count, fail_field, done, pass, overflow, gold_rd_en}, 32'h0);
    chk("t5_rst_addr", 32'(gold_addr), 32'h0);
    cyc();
    exp_q.delete();
    sb_next = 0;
    reset = 1'b0;
    send(0, 1'b1);
    wait_for(1, 1'b0);
    cyc(); cyc();
    chk("t5_mc", 32'(match_count), 32'd1);
    chk("t5_done", 32'(done), 32'd0);

    // Push coincident with pop while the FIFO is full
    do_reset();
    begin
      bit pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int idx = 0;
      for (int i = 0; i < 8; i++) begin
        if (pat[i]) begin
          send(idx, 1'b1);
          idx++;
        end else cyc();
      end
    end
    wait_for(6, 1'b0);
    cyc(); cyc();
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_mc", 32'(match_count), 32'd6);
    send(6, 1'b1);
    cyc(); cyc();
    send(7, 1'b1);
    wait_for(0, 1'b1);
    cyc(); cyc();
    chk("t6_pass", 32'(pass), 32'd1);
    chk("t6_mc_end", 32'(match_count), 32'(NREC));
    chk("t6_q", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
